// File: rtl/lag_meter.sv
// Multi-channel display-lag meter: BCD timebase started by start, per-channel capture on sensor light; optional LAG_METER_DEBOUNCE_EN.
// Capture latency 3 edges (+DEBOUNCE_CYCLES with debounce); no backpressure, results hold until next start/reset.
module lag_meter #(
    parameter int CLOCK_DIVIDER   = 270,
    parameter int DIGITS          = 5,
    parameter int CHANNELS        = 1,
    parameter int SENSOR_ACTIVE   = 0,
    parameter int DEBOUNCE_CYCLES = 27
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CHANNELS-1:0]          sensor,
    output logic [4*DIGITS-1:0]          bcd_count,
    output logic [4*DIGITS*CHANNELS-1:0] result,
    output logic [CHANNELS-1:0]          result_valid,
    output logic                         busy,
    output logic                         timeout
);

    localparam logic ACT   = (SENSOR_ACTIVE != 0);
    localparam logic INACT = ~ACT;
    localparam int   DIV_W = $clog2(CLOCK_DIVIDER);
    localparam int   CW    = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CHANNELS-1:0]        sync1_q, sync2_q, sens_f;
    logic [DIV_W-1:0]           div_q, div_d;
    logic                       tick;
    logic [CW-1:0]              count_q, count_d, count_inc;
    logic                       sat;
    logic [CW*CHANNELS-1:0]     result_q, result_d;
    logic [CHANNELS-1:0]        valid_q, valid_d;
    logic [CHANNELS-1:0]        armed_q, armed_d;
    logic                       timeout_q, timeout_d;
    logic                       busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= {CHANNELS{INACT}};
            sync2_q <= {CHANNELS{INACT}};
        end else begin
            sync1_q <= sensor;
            sync2_q <= sync1_q;
        end
    end

`ifdef LAG_METER_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CHANNELS-1:0]           deb_q, deb_d;
    logic [CHANNELS-1:0][DBW-1:0]  dcnt_q, dcnt_d;

    // Counter only runs while the synchronised level disagrees with the filtered one.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            deb_q  <= {CHANNELS{INACT}};
            dcnt_q <= '0;
        end else begin
            deb_q  <= deb_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign sens_f = deb_q;
`else
    assign sens_f = sync2_q;
`endif

    assign tick = (div_q == DIV_W'(CLOCK_DIVIDER - 1));
    assign div_d = (start || tick) ? '0 : div_q + 1'b1;
    assign sat  = (count_q == {DIGITS{4'h9}});

    always_comb begin
        logic carry;
        count_inc = count_q;
        carry     = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (count_q[4*d +: 4] == 4'd9) begin
                    count_inc[4*d +: 4] = 4'd0;
                end else begin
                    count_inc[4*d +: 4] = count_q[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // start overrides every other event in the same cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        result_d  = result_q;
        valid_d   = valid_q;
        armed_d   = armed_q;
        timeout_d = timeout_q;
        if (start) begin
            state_d   = S_MEASURE;
            count_d   = '0;
            valid_d   = '0;
            armed_d   = '0;
            timeout_d = 1'b0;
        end else if (state_q == S_MEASURE) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sens_f[i] != ACT) begin
                    armed_d[i] = 1'b1;
                end else if (armed_q[i] && !valid_q[i]) begin
                    valid_d[i]             = 1'b1;
                    result_d[i*CW +: CW]   = count_q;
                end
            end
            if (tick && !sat) begin
                count_d = count_inc;
            end
            if (&valid_d) begin
                state_d = S_DONE;
            end else if (tick && sat) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            count_q   <= '0;
            result_q  <= '0;
            valid_q   <= '0;
            armed_q   <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            count_q   <= count_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            armed_q   <= armed_d;
            timeout_q <= timeout_d;
            busy_q    <= (state_d == S_MEASURE);
        end
    end

    assign bcd_count    = count_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_lag_meter.sv
// Bench for lag_meter: per-cycle comparison against an arithmetic model of count, capture edges and timeout.
`timescale 1ns/1ps
module tb_lag_meter;

    localparam int CD   = 4;
    localparam int DIG  = 3;
    localparam int CH   = 3;
    localparam int DBC  = 27;
`ifdef LAG_METER_DEBOUNCE_EN
    localparam int DB   = DBC;
`else
    localparam int DB   = 0;
`endif
    localparam int DBMIN = (DB > 0) ? DB : 1;
    localparam int MAXC  = 999;
    localparam int TTO   = (MAXC + 1) * CD;
    localparam logic [11:0] T1_EXP = (DB > 0) ? 12'h017 : 12'h010;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CH-1:0]        sensor;
    logic [4*DIG-1:0]     bcd_count;
    logic [4*DIG*CH-1:0]  result;
    logic [CH-1:0]        result_valid;
    logic                 busy;
    logic                 timeout;

    int n_pass  = 0;
    int n_total = 0;

    // Per-channel waveform relative to the start edge T: initial level, then
    // toggles driven just after edges T+w_t1 and T+w_t2 (-1 = none).
    logic w_init [CH];
    int   w_t1   [CH];
    int   w_t2   [CH];

    lag_meter #(
        .CLOCK_DIVIDER(CD), .DIGITS(DIG), .CHANNELS(CH),
        .SENSOR_ACTIVE(0), .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .sensor(sensor),
        .bcd_count(bcd_count), .result(result), .result_valid(result_valid),
        .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [4*DIG-1:0] to_bcd(input int v);
        logic [4*DIG-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIG; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic idle(input logic lvl, input int n);
        sensor = {CH{lvl}};
        repeat (n) @(negedge clock);
    endtask

    // Issue start, then check every cycle up to T+ncyc against the model.
    task automatic measure(input int ncyc, input string name);
        int   e    [CH];
        bit   cap  [CH];
        int   fall, edone, kk;
        bit   vis, all_cap;
        logic [CH-1:0]    lvl, ev;
        logic [4*DIG-1:0] ec, er;
        all_cap = 1'b1;
        edone   = 0;
        for (int i = 0; i < CH; i++) begin
            if (w_init[i]) begin
                fall = w_t1[i];
                vis  = (w_t2[i] < 0) || (w_t2[i] - w_t1[i] >= DBMIN);
            end else begin
                fall = w_t2[i];
                vis  = (w_t1[i] >= 0) && (w_t2[i] - w_t1[i] >= DBMIN);
            end
            e[i]   = fall + 3 + DB;
            cap[i] = (fall >= 0) && vis && (e[i] < TTO);
            if (cap[i]) begin
                if (e[i] > edone) edone = e[i];
            end else begin
                all_cap = 1'b0;
            end
        end
        if (!all_cap) edone = TTO;

        for (int i = 0; i < CH; i++) lvl[i] = w_init[i];
        sensor = lvl;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k <= ncyc; k++) begin
            kk = (k < edone) ? k : edone;
            ec = to_bcd(((kk / CD) > MAXC) ? MAXC : (kk / CD));
            for (int i = 0; i < CH; i++) ev[i] = cap[i] && (k >= e[i]);
            n_total++;
            if (busy !== (k < edone)) $display("FAIL %s busy k=%0d got %b exp %b", name, k, busy, (k < edone));
            else n_pass++;
            n_total++;
            if (bcd_count !== ec) $display("FAIL %s count k=%0d got %h exp %h", name, k, bcd_count, ec);
            else n_pass++;
            n_total++;
            if (result_valid !== ev) $display("FAIL %s valid k=%0d got %b exp %b", name, k, result_valid, ev);
            else n_pass++;
            n_total++;
            if (timeout !== (!all_cap && k >= edone)) $display("FAIL %s timeout k=%0d got %b exp %b", name, k, timeout, (!all_cap && k >= edone));
            else n_pass++;
            for (int i = 0; i < CH; i++) begin
                if (ev[i]) begin
                    er = to_bcd((e[i] - 1) / CD);
                    n_total++;
                    if (result[i*4*DIG +: 4*DIG] !== er) $display("FAIL %s result%0d k=%0d got %h exp %h", name, i, k, result[i*4*DIG +: 4*DIG], er);
                    else n_pass++;
                end
            end
            for (int i = 0; i < CH; i++)
                lvl[i] = w_init[i] ^ (w_t1[i] >= 0 && k >= w_t1[i]) ^ (w_t2[i] >= 0 && k >= w_t2[i]);
            sensor = lvl;
            if (k < ncyc) @(negedge clock);
        end
    endtask

    task automatic set_wave(input int i, input logic init, input int t1, input int t2);
        w_init[i] = init;
        w_t1[i]   = t1;
        w_t2[i]   = t2;
    endtask

    task automatic test_reset();
        n_total++;
        if ({bcd_count, result, result_valid, busy, timeout} !== '0)
            $display("FAIL reset_state got count=%h valid=%b busy=%b to=%b exp all zero", bcd_count, result_valid, busy, timeout);
        else n_pass++;
    endtask

    task automatic test_basic();
        idle(1'b1, 40);
        set_wave(0, 1'b1, 41, -1);
        set_wave(1, 1'b1, 41, -1);
        set_wave(2, 1'b1, 70, -1);
        measure(70 + 3 + DB + 3, "basic");
        n_total++;
        if (result[11:0] !== T1_EXP) $display("FAIL basic_ch0 got %h exp %h", result[11:0], T1_EXP);
        else n_pass++;
        n_total++;
        if (result_valid !== 3'b111 || busy !== 1'b0) $display("FAIL basic_done got valid=%b busy=%b exp 111/0", result_valid, busy);
        else n_pass++;
    endtask

    task automatic test_arming();
        idle(1'b0, 40);
        set_wave(0, 1'b0, 10, 10 + 5 + DB);
        set_wave(1, 1'b0, -1, -1);
        set_wave(2, 1'b1, 60, -1);
        measure(10 + 5 + DB + 3 + DB + 10, "arming");
    endtask

    task automatic test_restart();
        idle(1'b1, 40);
        set_wave(0, 1'b1, 100, -1);
        set_wave(1, 1'b1, 200, -1);
        set_wave(2, 1'b1, 300, -1);
        measure(50, "restart_a");
        set_wave(0, 1'b1, 20, -1);
        set_wave(1, 1'b1, 150, -1);
        set_wave(2, 1'b1, 160, -1);
        measure(20 + 3 + DB - 1, "restart_b");
        set_wave(0, 1'b0, -1, -1);
        set_wave(1, 1'b1, 30, -1);
        set_wave(2, 1'b1, 30, -1);
        measure(30 + 3 + DB + 5, "restart_c");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < CH; i++) set_wave(i, 1'b1, -1, -1);
        measure(TTO + 6, "timeout");
        n_total++;
        if (bcd_count !== 12'h999 || timeout !== 1'b1 || busy !== 1'b0 || result_valid !== 3'b000)
            $display("FAIL timeout_end got count=%h to=%b busy=%b valid=%b exp 999/1/0/000", bcd_count, timeout, busy, result_valid);
        else n_pass++;
    endtask

    task automatic test_glitch();
        idle(1'b1, 40);
        set_wave(0, 1'b1, 30, 40);
        set_wave(1, 1'b1, 150, -1);
        set_wave(2, 1'b1, 150, -1);
        measure(200, "glitch");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int mx;
            idle(1'b1, 40);
            mx = 0;
            for (int i = 0; i < CH; i++) begin
                set_wave(i, 1'b1, int'($urandom_range(1, 200)), -1);
            end
            if (r % 2 == 1) w_t1[2] = w_t1[1];
            for (int i = 0; i < CH; i++) if (w_t1[i] > mx) mx = w_t1[i];
            measure(mx + 3 + DB + 4, "random");
        end
    endtask

    task automatic test_mid_reset();
        idle(1'b1, 40);
        for (int i = 0; i < CH; i++) set_wave(i, 1'b1, 500, -1);
        measure(30, "mid_reset");
        reset = 1'b1;
        @(negedge clock);
        n_total++;
        if ({bcd_count, result, result_valid, busy, timeout} !== '0)
            $display("FAIL mid_reset got count=%h result=%h valid=%b busy=%b exp all zero", bcd_count, result, result_valid, busy);
        else n_pass++;
        reset = 1'b0;
        idle(1'b1, 10);
        n_total++;
        if (busy !== 1'b0 || bcd_count !== '0) $display("FAIL post_reset_idle got busy=%b count=%h exp 0/0", busy, bcd_count);
        else n_pass++;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        sensor = '1;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_arming();
        test_restart();
        test_timeout();
        test_glitch();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lag_meter.md
# lag_meter

Parametrised multi-channel display-lag measurement core with BCD timebase. A `start` pulse, already crossed into the `clock` domain from the video generator's frame trigger, clears and starts a decimal counter that ticks every `CLOCK_DIVIDER` cycles. Each photosensor channel independently captures the count when its sensor becomes active. The block sits between the trigger crossing and the OSD/result formatter in the lag tester top, and generalises the single-sensor fixed-width counter to N channels, D digits, arming and timeout.

## Interface
- `CLOCK_DIVIDER`, 270: clock cycles per count tick (27 MHz / 270 = 10 µs); legal range ≥ 2.
- `DIGITS`, 5: number of BCD digits in the counter and in each result.
- `CHANNELS`, 1: number of sensor inputs.
- `SENSOR_ACTIVE`, 0: sensor level that means "light detected" (0 = active-low).
- `DEBOUNCE_CYCLES`, 27: stability window. Used only with `LAG_METER_DEBOUNCE_EN`.

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse that begins a measurement.
- `sensor` in CHANNELS: raw asynchronous sensor inputs.
- `bcd_count` out 4*DIGITS: running count, digit 0 in bits [3:0].
- `result` out 4*DIGITS*CHANNELS: captured count per channel; channel i occupies slice i.
- `result_valid` out CHANNELS: channel i has captured a value.
- `busy` out 1: high in state MEASURE.
- `timeout` out 1: measurement ended because the counter saturated.

## Operation
- Every `sensor` bit goes through a 2-flop synchroniser. The optional debounce follows, producing the filtered level `sens_f[i]`.
- Divider: counts 0..`CLOCK_DIVIDER`-1 and wraps. `tick` is high for the one cycle in which the divider equals `CLOCK_DIVIDER`-1. A `start` forces the divider to 0.
- BCD counter: each digit rolls 9→0 and carries to the next digit. It increments on `tick` only in MEASURE and saturates at all-9s (99999 for `DIGITS`=5). `start` clears it to 0.
- FSM states: IDLE, MEASURE, DONE.
  - IDLE→MEASURE on `start`.
  - MEASURE→DONE when all `result_valid` bits are set, or when `tick` occurs with the count at all-9s. The saturation case also sets `timeout`.
  - DONE→MEASURE on `start`.
- Arming: a per-channel `armed[i]` flag, cleared on `start`. It sets when `sens_f[i]` is at the inactive level during MEASURE, so a sensor that is already lit at `start` cannot capture.
- Capture: in MEASURE, when `armed[i]`, `sens_f[i]`==`SENSOR_ACTIVE` and `result_valid[i]`==0:
  - `result[i]` takes the `bcd_count` value present in that cycle, before any same-cycle increment;
  - `result_valid[i]` is set to 1.
- Each channel captures once per measurement. Results hold through DONE until the next `start` or `reset`.
- On `start`: `result_valid`, `armed` and `timeout` clear; `result` values are retained but are meaningless until valid is set.
- On timeout: channels not yet captured keep `result_valid`=0.
- Simultaneous events:
  - `start` has priority over capture, tick and timeout in the same cycle.
  - `start` during MEASURE restarts the measurement.
  - Captures on several channels in one cycle are all taken.
- `reset` at any time: state IDLE; divider, count, `result`, `result_valid`, `armed`, `timeout` and `busy` all 0; synchroniser and debounce registers are set to the inactive level.

## Timing
- `start` sampled at edge T gives: `busy`=1, `bcd_count`=0 and divider=0 after edge T.
- The first increment lands at edge T+`CLOCK_DIVIDER`; the count then advances by 1 every `CLOCK_DIVIDER` cycles.
- Sensor-to-capture latency: `result_valid` rises 3 edges after the input change (2 synchroniser edges + 1 capture edge), provided the channel is armed.
- With debounce enabled the latency is 3 + `DEBOUNCE_CYCLES` edges.
- `busy` falls on the same edge at which the last `result_valid` rises or `timeout` rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `LAG_METER_DEBOUNCE_EN` defined: `sens_f[i]` changes only after the synchronised input has held its new level for `DEBOUNCE_CYCLES` consecutive cycles. A per-channel counter restarts on every change.
- `LAG_METER_DEBOUNCE_EN` undefined: `sens_f` is the synchroniser output; no debounce counters are synthesised.

## Test plan
1. Sensor test (`CLOCK_DIVIDER`=4, `CHANNELS`=1, sensor idle high): `start` at T, sensor drops at T+41 → `result`=0x00010, `result_valid`=1, `busy`=0. The capture edge is T+44; count 10 is reached at T+40, the next tick at T+44.
2. Sensor held low before and after `start` → no capture. Then sensor high for 5 cycles and low again → capture occurs; the captured value is later than the first low.
3. Timeout (`DIGITS`=2, `CLOCK_DIVIDER`=2), sensor never active → `bcd_count` saturates at 0x99, `timeout`=1, `busy`=0, `result_valid`=0, and the count holds at 0x99.
4. `CHANNELS`=3 with sensors at staggered times, two of them in the same cycle → three independent correct results. `busy` clears only after the third capture.
5. `start` mid-measurement, and `start` in the same cycle as a capture → the capture is discarded, the count is 0, and `result_valid`=0.
6. `reset` asserted mid-MEASURE → all outputs 0 on the next edge. With `LAG_METER_DEBOUNCE_EN`, a 10-cycle glitch with `DEBOUNCE_CYCLES`=27 produces no capture.
